// File: rtl/serial_nibble_adder.sv
// WIDTH-bit adder that reuses an external 4-bit combinational adder, one nibble per clock.
// Operands are latched on start; the result, carry and overflow update together when the last nibble completes.
module serial_nibble_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [3:0]       adder_x,
  output logic [3:0]       adder_y,
  output logic             adder_cin,
  input  logic [3:0]       adder_sum,
  input  logic             adder_cout
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, work_q, work_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;
  logic [IW+1:0]    base;

  assign base = {idx_q, 2'b00};

  // The working register with the current nibble merged in; on the last nibble this is the full result.
  always_comb begin
    work_d = work_q;
    work_d[base +: 4] = adder_sum;
  end

  always_comb begin
    adder_x   = 4'h0;
    adder_y   = 4'h0;
    adder_cin = 1'b0;
    if (state_q == RUN) begin
      adder_x   = a_q[base +: 4];
      adder_y   = b_q[base +: 4];
      adder_cin = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          work_q  <= work_d;
          carry_q <= adder_cout;
          idx_q   <= (idx_q == LAST) ? '0 : idx_q + IW'(1);
          if (idx_q == LAST) begin
            sum_q   <= work_d;
            cout_q  <= adder_cout;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (adder_sum[3] != a_q[WIDTH-1]);
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: doc/serial_nibble_adder.md
# serial_nibble_adder

Multi-cycle WIDTH-bit adder controller that drives the team's 4-bit combinational adder (X, Y, Cin → Sum, Cout) one nibble per clock, least-significant nibble first. It latches operands on a start handshake, feeds each nibble and the running carry to the adder, and captures the adder's Sum/Cout. It then presents the assembled WIDTH-bit result with carry-out and signed overflow. It sits directly upstream of the 4-bit adder and is also the consumer of its outputs.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4
- NIB, WIDTH/4, derived nibble count; not overridden
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- a  input  WIDTH  operand A, sampled on the accepting edge
- b  input  WIDTH  operand B, sampled on the accepting edge
- cin  input  1  carry-in, sampled on the accepting edge
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse; sum, cout and overflow are valid and newly updated
- sum  output  WIDTH  result; holds until the next completion
- cout  output  1  carry out of bit WIDTH-1
- overflow  output  1  two's-complement overflow
- adder_x  output  4  to adder X
- adder_y  output  4  to adder Y
- adder_cin  output  1  to adder Cin
- adder_sum  input  4  from adder Sum
- adder_cout  input  1  from adder Cout

## Operation
- States: IDLE, RUN, DONE. The state register, nibble index idx (width clog2(NIB), minimum 1), carry register, operand registers, working result register and output registers are all clocked by clk.
- Reset: state=IDLE, idx=0, carry=0, busy=0, done=0, sum=0, cout=0, overflow=0, operand and working registers cleared. Reset takes priority over every other event, including mid-RUN; a reset aborts the operation with no partial result.
- IDLE/DONE + start=1: latch a, b and cin; carry←cin; idx←0; go to RUN.
- IDLE + start=0: stay in IDLE. DONE + start=0: go to IDLE.
- RUN, combinational: adder_x=a_reg[4·idx+3:4·idx], adder_y=b_reg[4·idx+3:4·idx], adder_cin=carry.
- RUN, each edge: work[4·idx+3:4·idx]←adder_sum; carry←adder_cout; idx←idx+1.
- RUN, edge with idx=NIB-1: additionally sum←{adder_sum, work[4·idx-1:0]}, cout←adder_cout, overflow←(a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (adder_sum[3]!=a_reg[WIDTH-1]), and go to DONE.
- Outside RUN: adder_x=0, adder_y=0, adder_cin=0.
- busy=1 exactly when state=RUN. done=1 exactly when state=DONE.
- start while busy=1 is ignored: it is not queued, and the in-flight operands are unchanged.
- The adder is zero-latency combinational. Its Sum/Cout must settle within one clk period.

## Timing
- Start accepted at edge E0. RUN cycles follow E0, with captures at E1..E_NIB (nibble 0..NIB-1).
- State is DONE after E_NIB: done=1 and new sum/cout/overflow are visible in that cycle. Latency is NIB cycles from the accepting edge to done; for WIDTH=16 this is 4.
- sum/cout/overflow change only at the E_NIB edge (or at reset). Partial nibbles are never visible on sum.
- start=1 during the DONE cycle is accepted at E_NIB+1. This gives back-to-back operations with a throughput of one result every NIB+1 cycles.
- start high continuously from IDLE: operations repeat every NIB+1 cycles, with a one-cycle done pulse each time.
- WIDTH=4: one RUN cycle; idx stays 0.

## Test plan
- a=0x1234, b=0x4321, cin=0 → done 4 cycles after the accept edge; sum=0x5555, cout=0, overflow=0; busy high for exactly 4 cycles.
- a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, overflow=0; adder_cin=1 on all four RUN cycles (full carry ripple).
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, overflow=1. Then a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1, overflow=1.
- Start a=0x0009, b=0x0006, cin=1; in the second RUN cycle assert start with a=0xFFFF, b=0xFFFF → the second start is ignored; result is sum=0x0010, cout=0; a single done pulse.
- rst=1 during the third RUN cycle → after that edge busy=0, done=0, sum=0, cout=0, overflow=0, state IDLE, adder_* outputs are 0. A subsequent start with a=0x0005, b=0x0006, cin=0 → sum=0x000B.
- start held during the DONE cycle with new operands a=0x0F0F, b=0x00F1, cin=0 → the second op is accepted immediately; the first result holds through the second op's RUN; the second done gives sum=0x1000, cout=0, overflow=0.
